rgbw_fade_sequencer: RTL and testbench
======================================

// Module: rgbw_fade_sequencer
// PURPOSE
//  Sits between the SPI data dispenser/colour generator and the 4-channel PWM generator.
//  Accepts a new RGBW target set, ramps the 4 working duties toward it at a programmable rate,
//  and commits the ramp steps to the PWM duty inputs.
//  Commits happen only on PWM period boundaries, so duties never change mid-period.
// PARAMETERS
//  DUTY_W   16  width of each duty/target value
//  DIV_W    16  width of tick prescaler / fade_div
//  STEP_W   8   width of fade_step
// PORTS
//  clk12          in   1       system clock; only clock of the block
//  reset          in   1       synchronous, active-high reset
//  tgt_valid      in   1       target set valid (producer holds until accepted)
//  tgt_ready      out  1       block can accept a target set
//  tgt_red/green/blue/white in DUTY_W each  target duties, sampled on transfer
//  fade_step      in   STEP_W  duty increment per tick; 0 = jump directly to target
//  fade_div       in   DIV_W   tick period = fade_div+1 clk12 cycles (sampled live)
//  pwm_period_end in   1       1-cycle pulse from PWM generator at period wrap
//  duty_red/green/blue/white out DUTY_W each  duties driven to PWM generator
//  duty_upd       out  1       1-cycle pulse: duty_* changed this cycle
//  busy           out  1       high whenever state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; duty_*=0, working regs=0, target regs=0, prescaler=0,
//   duty_upd=0, busy=0, tgt_ready=1. Reset mid-ramp aborts; outputs 0 after that edge.
//  Transfer = tgt_valid & tgt_ready on a rising clk12 edge; latches tgt_* into target regs.
//  tgt_ready=1 in IDLE and RAMP, 0 in LOAD and COMMIT (producer must hold valid).
//  States:
//   IDLE   -> LOAD on transfer.
//   LOAD   (1 cycle): prescaler<=0.
//          If working==target on all 4 channels: -> IDLE, no duty_upd.
//          Else if fade_step==0: working<=target; -> COMMIT.
//          Else -> RAMP.
//   RAMP   prescaler increments each cycle. Tick when prescaler>=fade_div; on tick,
//          prescaler<=0 and -> COMMIT. Per channel on tick:
//          |tgt-cur|<=fade_step -> cur<=tgt; else cur<=cur+/-fade_step.
//          Unsigned arithmetic in DUTY_W+1 bits; never overshoots, never wraps.
//          Transfer in RAMP: new targets latched, working regs kept,
//          -> LOAD; a coincident tick is discarded.
//   COMMIT wait for pwm_period_end. On it: duty_*<=working (visible next cycle) and
//          duty_upd=1 in that same next cycle.
//          Then -> IDLE if working==target on all channels, else -> RAMP (prescaler=0).
//  pwm_period_end outside COMMIT is ignored. Target/working updates never reach duty_* except via COMMIT.
//  fade_div=0 -> tick every RAMP cycle. fade_div lowered below prescaler -> tick next cycle (>= compare).
//  Max one commit per PWM period; ramp duration = ceil(max|delta|/fade_step) commits.
//  busy = (state != IDLE); duty_* hold between commits.
// TESTING
//  1 Reset: assert reset 2 cycles mid-ramp -> all duty_*=0, busy=0, tgt_ready=1, duty_upd=0.
//  2 Jump: fade_step=0, targets R=0x1234,G=0xFFFF,B=0,W=0x8000 -> single duty_upd after the next
//    pwm_period_end; duties equal targets; busy falls the following cycle.
//  3 Ramp: from 0, target R=0x0100 (others 0), fade_step=0x40, fade_div=3 -> exactly 4 duty_upd
//    pulses, R=0x40,0x80,0xC0,0x100; each pulse aligned to pwm_period_end; no overshoot.
//  4 Saturation: cur=0xFFF0, target 0xFFFF, fade_step=0xFF -> one commit to 0xFFFF (no wrap);
//    down-ramp 0x0005->0 with step 0x10 -> 0.
//  5 Preempt: mid-ramp (R=0x80 toward 0x100), transfer target R=0 -> ramp reverses from current
//    working value; tgt_ready low during LOAD/COMMIT and valid held until accepted.
//  6 No-op: transfer targets equal to current duties -> LOAD->IDLE, zero duty_upd pulses, busy high 1 cycle.

Source files
------------

// File: rtl/rgbw_fade_sequencer.sv
// Purpose: ramps four RGBW working duties toward a latched target set and commits them to the PWM block.
// Latency: target accepted -> LOAD (1 cycle) -> RAMP ticks every fade_div+1 cycles -> commit on next pwm_period_end.
// Backpressure: tgt_ready is low in LOAD/COMMIT; the producer holds tgt_valid and the target set until accepted.
//
// Ports:
//   clk12, reset                       clock, synchronous active-high reset
//   tgt_valid/tgt_ready, tgt_*         target set handshake and RGBW target duties
//   fade_step, fade_div                step per tick (0 = jump) and tick period minus one (sampled live)
//   pwm_period_end                     period-wrap pulse from the PWM generator; gates every commit
//   duty_*, duty_upd, busy             committed duties, 1-cycle update strobe, state != IDLE
module rgbw_fade_sequencer #(
  parameter int DUTY_W = 16,
  parameter int DIV_W  = 16,
  parameter int STEP_W = 8
) (
  input  logic              clk12,
  input  logic              reset,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [DUTY_W-1:0] tgt_red,
  input  logic [DUTY_W-1:0] tgt_green,
  input  logic [DUTY_W-1:0] tgt_blue,
  input  logic [DUTY_W-1:0] tgt_white,
  input  logic [STEP_W-1:0] fade_step,
  input  logic [DIV_W-1:0]  fade_div,
  input  logic              pwm_period_end,
  output logic [DUTY_W-1:0] duty_red,
  output logic [DUTY_W-1:0] duty_green,
  output logic [DUTY_W-1:0] duty_blue,
  output logic [DUTY_W-1:0] duty_white,
  output logic              duty_upd,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RAMP, COMMIT} state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  presc_q;
  logic [DUTY_W-1:0] cur_q   [4];
  logic [DUTY_W-1:0] tgt_q   [4];
  logic [DUTY_W-1:0] tgt_in  [4];
  logic [DUTY_W-1:0] cur_nxt [4];
  logic              all_eq;

  assign tgt_in[0] = tgt_red;
  assign tgt_in[1] = tgt_green;
  assign tgt_in[2] = tgt_blue;
  assign tgt_in[3] = tgt_white;

  assign tgt_ready = (state_q == IDLE) || (state_q == RAMP);
  assign busy      = (state_q != IDLE);

  // One ramp step in DUTY_W+1 bits: when the remaining distance is within
  // one step we land exactly on the target, so the value can neither
  // overshoot nor wrap past 0 / all-ones.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [STEP_W-1:0] stp
  );
    logic [DUTY_W:0] c;
    logic [DUTY_W:0] t;
    logic [DUTY_W:0] s;
    logic [DUTY_W:0] diff;
    logic [DUTY_W:0] res;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    s = (DUTY_W + 1)'(stp);
    diff = (t >= c) ? (t - c) : (c - t);
    if (diff <= s)   res = t;
    else if (t > c)  res = c + s;
    else             res = c - s;
    return res[DUTY_W-1:0];
  endfunction

  always_comb begin
    all_eq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cur_nxt[i] = step_toward(cur_q[i], tgt_q[i], fade_step);
      if (cur_q[i] != tgt_q[i]) all_eq = 1'b0;
    end
  end

  always_ff @(posedge clk12) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      duty_red   <= '0;
      duty_green <= '0;
      duty_blue  <= '0;
      duty_white <= '0;
      duty_upd   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cur_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      duty_upd <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tgt_valid) begin
            for (int i = 0; i < 4; i++) tgt_q[i] <= tgt_in[i];
            state_q <= LOAD;
          end
        end
        LOAD: begin
          presc_q <= '0;
          if (all_eq) begin
            state_q <= IDLE;
          end else if (fade_step == '0) begin
            for (int i = 0; i < 4; i++) cur_q[i] <= tgt_q[i];
            state_q <= COMMIT;
          end else begin
            state_q <= RAMP;
          end
        end
        RAMP: begin
          // A new target set wins over a coincident tick; working values are
          // kept so the ramp continues from where it is.
          if (tgt_valid) begin
            for (int i = 0; i < 4; i++) tgt_q[i] <= tgt_in[i];
            state_q <= LOAD;
          end else if (presc_q >= fade_div) begin
            presc_q <= '0;
            for (int i = 0; i < 4; i++) cur_q[i] <= cur_nxt[i];
            state_q <= COMMIT;
          end else begin
            presc_q <= presc_q + DIV_W'(1);
          end
        end
        COMMIT: begin
          if (pwm_period_end) begin
            duty_red   <= cur_q[0];
            duty_green <= cur_q[1];
            duty_blue  <= cur_q[2];
            duty_white <= cur_q[3];
            duty_upd   <= 1'b1;
            presc_q    <= '0;
            state_q    <= all_eq ? IDLE : RAMP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgbw_fade_sequencer.sv
// Purpose: directed bench for rgbw_fade_sequencer with a free-running PWM period source.
// Latency: not applicable (bench).
// Backpressure: the send task holds tgt_valid until tgt_ready is seen.
module tb_rgbw_fade_sequencer;

  logic        clk12 = 1'b0;
  logic        reset;
  logic        tgt_valid;
  logic        tgt_ready;
  logic [15:0] tgt_red, tgt_green, tgt_blue, tgt_white;
  logic [7:0]  fade_step;
  logic [15:0] fade_div;
  logic        pwm_period_end;
  logic [15:0] duty_red, duty_green, duty_blue, duty_white;
  logic        duty_upd;
  logic        busy;

  always #5 clk12 = ~clk12;

  rgbw_fade_sequencer dut (
    .clk12(clk12), .reset(reset),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_red(tgt_red), .tgt_green(tgt_green), .tgt_blue(tgt_blue), .tgt_white(tgt_white),
    .fade_step(fade_step), .fade_div(fade_div),
    .pwm_period_end(pwm_period_end),
    .duty_red(duty_red), .duty_green(duty_green), .duty_blue(duty_blue), .duty_white(duty_white),
    .duty_upd(duty_upd), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // PWM period of 10 cycles: pulse driven away from the active edge.
  int pcnt = 0;
  initial begin
    pwm_period_end = 1'b0;
    forever begin
      @(negedge clk12);
      pwm_period_end = (pcnt == 9);
      pcnt = (pcnt == 9) ? 0 : pcnt + 1;
    end
  end

  // Every duty_upd must directly follow a cycle with pwm_period_end high.
  int          upd_cnt = 0;
  logic [15:0] r_log[$];
  logic        busy_at_upd;
  logic        pwm_seen;
  initial begin
    forever begin
      @(posedge clk12);
      pwm_seen = pwm_period_end;
      @(negedge clk12);
      if (duty_upd) begin
        upd_cnt++;
        r_log.push_back(duty_red);
        busy_at_upd = busy;
        check_eq("upd_aligned_to_pwm", {31'b0, pwm_seen}, 32'd1);
      end
    end
  end

  function automatic logic [31:0] log_at(input int i);
    if (r_log.size() > i) return {16'b0, r_log[i]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic clear_log();
    upd_cnt = 0;
    r_log.delete();
  endtask

  task automatic send(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                      input logic [15:0] w, output int waited);
    @(negedge clk12);
    tgt_red = r; tgt_green = g; tgt_blue = b; tgt_white = w;
    tgt_valid = 1'b1;
    waited = 0;
    while (!tgt_ready && waited < 50) begin
      @(negedge clk12);
      waited++;
    end
    check_eq("send_accepted", {31'b0, tgt_ready}, 32'd1);
    @(negedge clk12);
    tgt_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk12);
      n++;
    end
    check_eq(tag, {31'b0, busy}, 32'd0);
    @(negedge clk12);
  endtask

  int w0, w1, snap;
  logic [15:0] exp_ramp [4] = '{16'h0040, 16'h0080, 16'h00C0, 16'h0100};
  logic [15:0] exp_pre  [4] = '{16'h0040, 16'h0080, 16'h0040, 16'h0000};

  initial begin
    reset = 1'b1; tgt_valid = 1'b0;
    tgt_red = '0; tgt_green = '0; tgt_blue = '0; tgt_white = '0;
    fade_step = '0; fade_div = '0;
    repeat (2) @(negedge clk12);
    check_eq("rst_duty_red", {16'b0, duty_red}, 32'd0);
    check_eq("rst_duty_white", {16'b0, duty_white}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_ready", {31'b0, tgt_ready}, 32'd1);
    check_eq("rst_upd", {31'b0, duty_upd}, 32'd0);
    reset = 1'b0;

    // Jump: fade_step 0 commits targets on the next PWM boundary.
    clear_log();
    send(16'h1234, 16'hFFFF, 16'h0000, 16'h8000, w0);
    check_eq("jump_ready_load", {31'b0, tgt_ready}, 32'd0);
    check_eq("jump_busy_load", {31'b0, busy}, 32'd1);
    @(negedge clk12);
    check_eq("jump_ready_commit", {31'b0, tgt_ready}, 32'd0);
    wait_idle("jump_done");
    check_eq("jump_upd_cnt", upd_cnt, 32'd1);
    check_eq("jump_red", {16'b0, duty_red}, 32'h1234);
    check_eq("jump_green", {16'b0, duty_green}, 32'hFFFF);
    check_eq("jump_blue", {16'b0, duty_blue}, 32'h0000);
    check_eq("jump_white", {16'b0, duty_white}, 32'h8000);
    check_eq("jump_busy_at_upd", {31'b0, busy_at_upd}, 32'd0);

    // No-op: same targets -> LOAD then straight back to IDLE.
    clear_log();
    send(16'h1234, 16'hFFFF, 16'h0000, 16'h8000, w0);
    check_eq("noop_busy_load", {31'b0, busy}, 32'd1);
    @(negedge clk12);
    check_eq("noop_idle_next", {31'b0, busy}, 32'd0);
    repeat (25) @(negedge clk12);
    check_eq("noop_upd_cnt", upd_cnt, 32'd0);
    check_eq("noop_red_held", {16'b0, duty_red}, 32'h1234);

    // Ramp from 0 to 0x100 in 0x40 steps.
    send(16'h0, 16'h0, 16'h0, 16'h0, w0);
    wait_idle("zero_done");
    clear_log();
    fade_step = 8'h40; fade_div = 16'd3;
    send(16'h0100, 16'h0, 16'h0, 16'h0, w0);
    wait_idle("ramp_done");
    check_eq("ramp_upd_cnt", upd_cnt, 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("ramp_r%0d", i), log_at(i), {16'b0, exp_ramp[i]});
    check_eq("ramp_green", {16'b0, duty_green}, 32'd0);

    // Saturation upward: 0xFFF0 -> 0xFFFF with step 0xFF, no wrap.
    fade_step = 8'h00;
    send(16'hFFF0, 16'h0, 16'h0, 16'h0, w0);
    wait_idle("sat_pre_done");
    clear_log();
    fade_step = 8'hFF; fade_div = 16'd0;
    send(16'hFFFF, 16'h0, 16'h0, 16'h0, w0);
    wait_idle("sat_up_done");
    check_eq("sat_up_cnt", upd_cnt, 32'd1);
    check_eq("sat_up_red", {16'b0, duty_red}, 32'hFFFF);

    // Saturation downward: 0x5 -> 0 with step 0x10.
    fade_step = 8'h00;
    send(16'h0005, 16'h0, 16'h0, 16'h0, w0);
    wait_idle("sat_dn_pre_done");
    clear_log();
    fade_step = 8'h10;
    send(16'h0000, 16'h0, 16'h0, 16'h0, w0);
    wait_idle("sat_dn_done");
    check_eq("sat_dn_cnt", upd_cnt, 32'd1);
    check_eq("sat_dn_red", {16'b0, duty_red}, 32'h0000);

    // Preempt: reverse at 0x80 on the way to 0x100.
    clear_log();
    fade_step = 8'h40; fade_div = 16'd3;
    send(16'h0100, 16'h0, 16'h0, 16'h0, w0);
    w1 = 0;
    while (duty_red != 16'h0080 && w1 < 200) begin
      @(negedge clk12);
      w1++;
    end
    check_eq("pre_reached_80", {16'b0, duty_red}, 32'h0080);
    send(16'h0000, 16'h0, 16'h0, 16'h0, w0);
    check_eq("pre_no_wait_in_ramp", w0, 32'd0);
    wait_idle("pre_done");
    check_eq("pre_upd_cnt", upd_cnt, 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("pre_r%0d", i), log_at(i), {16'b0, exp_pre[i]});

    // Held valid: second transfer must wait out LOAD/COMMIT.
    clear_log();
    fade_step = 8'h00;
    send(16'h0AAA, 16'h0, 16'h0, 16'h0, w0);
    send(16'h0555, 16'h0, 16'h0, 16'h0, w1);
    check_eq("hold_waited", {31'b0, (w1 > 0)}, 32'd1);
    wait_idle("hold_done");
    check_eq("hold_upd_cnt", upd_cnt, 32'd2);
    check_eq("hold_r0", log_at(0), 32'h0AAA);
    check_eq("hold_r1", log_at(1), 32'h0555);

    // Reset mid-ramp: slow ramp down by 1, abort after a couple of commits.
    clear_log();
    fade_step = 8'h01; fade_div = 16'd0;
    send(16'h0000, 16'h0, 16'h0, 16'h0, w0);
    w1 = 0;
    while (upd_cnt < 2 && w1 < 200) begin
      @(negedge clk12);
      w1++;
    end
    check_eq("mid_ramp_commits", {31'b0, (upd_cnt >= 2)}, 32'd1);
    reset = 1'b1;
    @(negedge clk12);
    check_eq("midrst_red", {16'b0, duty_red}, 32'd0);
    check_eq("midrst_busy", {31'b0, busy}, 32'd0);
    check_eq("midrst_ready", {31'b0, tgt_ready}, 32'd1);
    check_eq("midrst_upd", {31'b0, duty_upd}, 32'd0);
    @(negedge clk12);
    reset = 1'b0;
    snap = upd_cnt;
    repeat (30) @(negedge clk12);
    check_eq("post_rst_no_upd", upd_cnt, snap);
    check_eq("post_rst_red", {16'b0, duty_red}, 32'd0);
    check_eq("post_rst_busy", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
